e_bypass_unit: RTL

Parametrised E-stage operand bypass and hazard unit for the pipelined CPU. It supersedes the fixed two-way RD2 forwarding mux: one instance serves every E-stage read port. It tracks the destination, write-enable, Tnew and link status of every in-flight instruction in an internal shift pipeline over DEPTH post-E stages. From that record it selects forwarded operands per port and raises a stall when the youngest producer's data is not ready.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/bypass_port.sv | 45 ++++
 rtl/e_bypass_unit.sv | 91 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types, encodings and helpers used by the bypass logic.
package cpu_pkg;
  localparam int REG_W  = 5;
  localparam int TNEW_W = 2;
  localparam int SRC_W  = 3;
  localparam int TMAX_W = 8;

  localparam logic [SRC_W-1:0] RF_SRC = '0;

  // Saturating decrement; callers cast narrower Tnew fields in and out.
  function automatic logic [TMAX_W-1:0] sat_dec(input logic [TMAX_W-1:0] t);
    return (t == '0) ? t : t - TMAX_W'(1);
  endfunction
endpackage

// File: rtl/bypass_port.sv
// One E-stage read port: youngest-match forwarding select and per-port stall.
// Purely combinational; stage 0 of the flattened record vectors is the M stage.
module bypass_port
  import cpu_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 2,
  parameter int TW    = TNEW_W
) (
  input  logic [DEPTH-1:0]       vld_i,
  input  logic [DEPTH*REG_W-1:0] wa_i,
  input  logic [DEPTH*TW-1:0]    tnew_i,
  input  logic [DEPTH-1:0]       link_i,
  input  logic [DEPTH*DW-1:0]    pc8_i,
  input  logic [DEPTH*DW-1:0]    stg_val_i,
  input  logic [REG_W-1:0]       ra_i,
  input  logic [DW-1:0]          rf_i,
  input  logic                   need_i,
  output logic [DW-1:0]          data_o,
  output logic [SRC_W-1:0]       src_o,
  output logic                   stall_o
);

  logic hit;

  always_comb begin
    hit     = 1'b0;
    data_o  = rf_i;
    src_o   = RF_SRC;
    stall_o = 1'b0;
    // First match from the young end wins, even if it is not ready yet.
    for (int s = 0; s < DEPTH; s++) begin
      if (!hit && vld_i[s] && (wa_i[s*REG_W +: REG_W] == ra_i)) begin
        hit   = 1'b1;
        src_o = SRC_W'(s + 1);
        if (tnew_i[s*TW +: TW] == '0) begin
          data_o = link_i[s] ? pc8_i[s*DW +: DW] : stg_val_i[s*DW +: DW];
        end else begin
          stall_o = need_i;
        end
      end
    end
  end

endmodule

// File: rtl/e_bypass_unit.sv
// E-stage operand bypass/hazard unit: tracks DEPTH post-E stage records and
// forwards per read port; outputs are combinational from records and inputs.
module e_bypass_unit
  import cpu_pkg::*;
#(
  parameter int DW    = 32,
  parameter int NRP   = 2,
  parameter int DEPTH = 2,
  parameter int TW    = TNEW_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 e_hold,
  input  logic                 flush,
  input  logic                 e_we,
  input  logic [REG_W-1:0]     e_wa,
  input  logic [TW-1:0]        e_tnew,
  input  logic                 e_link,
  input  logic [DW-1:0]        e_pc8,
  input  logic [DEPTH*DW-1:0]  stg_val,
  input  logic [NRP*REG_W-1:0] rp_ra,
  input  logic [NRP*DW-1:0]    rp_rf,
  input  logic [NRP-1:0]       rp_need,
  output logic [NRP*DW-1:0]    rp_data,
  output logic [NRP*SRC_W-1:0] rp_src,
  output logic                 stall
);

  logic [DEPTH-1:0]            vld_q,  vld_d;
  logic [DEPTH-1:0][REG_W-1:0] wa_q,   wa_d;
  logic [DEPTH-1:0][TW-1:0]    tnew_q, tnew_d;
  logic [DEPTH-1:0]            link_q, link_d;
  logic [DEPTH-1:0][DW-1:0]    pc8_q,  pc8_d;
  logic [NRP-1:0]              port_stall;

  always_comb begin
    // Writes to $0 never become forwarding candidates.
    vld_d[0]  = !e_hold && e_we && (e_wa != '0);
    wa_d[0]   = e_wa;
    tnew_d[0] = TW'(sat_dec(TMAX_W'(e_tnew)));
    link_d[0] = e_link;
    pc8_d[0]  = e_pc8;
    for (int s = 1; s < DEPTH; s++) begin
      vld_d[s]  = vld_q[s-1];
      wa_d[s]   = wa_q[s-1];
      tnew_d[s] = TW'(sat_dec(TMAX_W'(tnew_q[s-1])));
      link_d[s] = link_q[s-1];
      pc8_d[s]  = pc8_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      vld_q  <= '0;
      wa_q   <= '0;
      tnew_q <= '0;
      link_q <= '0;
      pc8_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      wa_q   <= wa_d;
      tnew_q <= tnew_d;
      link_q <= link_d;
      pc8_q  <= pc8_d;
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_port
    bypass_port #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .TW    (TW)
    ) u_port (
      .vld_i     (vld_q),
      .wa_i      (wa_q),
      .tnew_i    (tnew_q),
      .link_i    (link_q),
      .pc8_i     (pc8_q),
      .stg_val_i (stg_val),
      .ra_i      (rp_ra[p*REG_W +: REG_W]),
      .rf_i      (rp_rf[p*DW +: DW]),
      .need_i    (rp_need[p]),
      .data_o    (rp_data[p*DW +: DW]),
      .src_o     (rp_src[p*SRC_W +: SRC_W]),
      .stall_o   (port_stall[p])
    );
  end

  assign stall = |port_stall;

endmodule
